reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port register file: the next generation of the team's single 32-bit register.
- Provides DEPTH entries of WIDTH bits, two combinational read ports and one clocked write port.
- Optional hardwired zero entry and optional write-to-read bypass.
- Built-in sequential bulk-clear engine with a busy/done handshake, used by the processor datapath for GPR storage and context wipe.

Parameters:
WIDTH, 32, data bits per entry
DEPTH, 32, number of entries (2..256, need not be a power of two)
ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching read port

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; asynchronous, active-low
rdAddrA  in  ADDR_W  read port A address
rdDataA  out  WIDTH  read port A data (combinational)
rdAddrB  in  ADDR_W  read port B address
rdDataB  out  WIDTH  read port B data (combinational)
writeEnable  in  1  write strobe for the current cycle
writeAddr  in  ADDR_W  write address
writeData  in  WIDTH  write data
clearReq  in  1  single-cycle request to zero every entry
clearBusy  out  1  high while the clear engine is running
clearDone  out  1  one-cycle pulse when the clear completes

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. rst low immediately forces all entries to 0, FSM to IDLE, clear index to 0, clearBusy=0, clearDone=0, independent of clk. Reset asserted mid-clear aborts the clear with no clearDone pulse.
- Write: on a rising clk edge with writeEnable=1, FSM in IDLE, writeAddr<DEPTH and not (ZERO_REG=1 and writeAddr=0), entry[writeAddr] <= writeData. All other cases ignore the write; no error flag.
- Read: rdDataX = entry[rdAddrX], purely combinational, zero-cycle latency.
  - rdAddrX>=DEPTH -> 0.
  - ZERO_REG=1 and rdAddrX=0 -> 0.
  - Both ports may address the same entry.
- Bypass (BYPASS=1): if writeEnable=1, FSM in IDLE, writeAddr=rdAddrX and the write would be accepted, then rdDataX=writeData in the same cycle. BYPASS=0 returns old contents until the edge.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clearReq=1 at an edge -> CLEAR with index<=0. A write presented on that same edge is still performed.
  - CLEAR: each edge zeroes entry[index] and increments index. The edge that zeroes index=DEPTH-1 -> DONE. Takes exactly DEPTH cycles.
  - DONE: one cycle, then unconditionally -> IDLE.
  - clearBusy=1 in CLEAR and DONE. clearDone=1 only in DONE.
  - clearReq while not IDLE is ignored and is not queued.
  - writeEnable while clearBusy=1 is dropped.
  - Reads during the clear return the current array contents, so entries not yet cleared still show old data. Bypass is disabled while busy.
  - A new clearReq in the DONE cycle is ignored. One sampled in the following IDLE cycle starts a new clear.
- Width: writeData stored unmodified, no sign handling; ADDR_W bits are compared in full.

Test Plan:
1. Reset then read: rst low 2 cycles, release -> rdDataA/B=0 for every address 0..DEPTH-1; clearBusy=0, clearDone=0.
2. Write/readback: write 0xDEADBEEF to addr 5 and 0x12345678 to addr 31; next cycle rdAddrA=5, rdAddrB=31 -> 0xDEADBEEF and 0x12345678.
3. Zero reg and bypass: write 0xFFFFFFFF to addr 0 -> reads 0. Same-cycle write 0xA5A5A5A5 to addr 7 with rdAddrA=7 -> rdDataA=0xA5A5A5A5 before the edge (BYPASS=1); old value when BYPASS=0.
4. Bulk clear: fill all entries with nonzero values, pulse clearReq -> clearBusy high for DEPTH+1 cycles (32 CLEAR + 1 DONE), clearDone high exactly in cycle 33. Entry k reads 0 from edge k+1 onward, and all entries read 0 afterwards.
5. Collisions: during a clear, writeEnable to addr 3 with 0x55 is dropped and reads 0 after the clear. A second clearReq mid-clear causes no extra cycles. clearReq with a write to addr 9 in IDLE -> write lands, then gets cleared.
6. Async reset mid-clear: assert rst at index 10 between edges -> clearBusy drops immediately, all entries read 0, no clearDone pulse.

Source files
------------

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
//   Parametrised multi-port register file: DEPTH entries of WIDTH bits with
//   two combinational read ports, one clocked write port, an optional
//   hardwired zero entry, optional write-to-read forwarding and a sequential
//   bulk-clear engine (IDLE -> CLEAR -> DONE) with a busy/done handshake.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-low reset
//   rdAddrA/B    read port addresses
//   rdDataA/B    read port data, combinational
//   writeEnable  write strobe for the current cycle
//   writeAddr    write address
//   writeData    write data
//   clearReq     single-cycle request to zero every entry
//   clearBusy    high while the clear engine is in CLEAR or DONE
//   clearDone    one-cycle pulse in the DONE state
// -----------------------------------------------------------------------------
module reg_file_mp #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rdAddrA,
   output logic [WIDTH-1:0]  rdDataA,
   input  logic [ADDR_W-1:0] rdAddrB,
   output logic [WIDTH-1:0]  rdDataB,
   input  logic              writeEnable,
   input  logic [ADDR_W-1:0] writeAddr,
   input  logic [WIDTH-1:0]  writeData,
   input  logic              clearReq,
   output logic              clearBusy,
   output logic              clearDone
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } state_t;

   // One extra bit so DEPTH itself is representable when ADDR_W is tight.
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] idx_reg, idx_next;
   logic [WIDTH-1:0]  entries [DEPTH];
   logic              wr_ok;

   // An address that maps onto real, writable/readable storage.
   function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_EXT) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Writes are only honoured while the clear engine is idle.
   assign wr_ok = writeEnable && (state_reg == IDLE) && addr_valid(writeAddr);

   // ---------------------------------------------------------------- storage
   // Flop-based storage: the asynchronous reset has to zero every entry at
   // once, which block RAM cannot do.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic             clr_hit;
         logic             wr_hit;
         logic [WIDTH-1:0] entry_reg;

         assign clr_hit = (state_reg == CLEAR) && (idx_reg == ADDR_W'(gi));
         assign wr_hit  = wr_ok && (writeAddr == ADDR_W'(gi));

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               entry_reg <= '0;
            end else if (clr_hit) begin
               entry_reg <= '0;
            end else if (wr_hit) begin
               entry_reg <= writeData;
            end
         end

         assign entries[gi] = entry_reg;
      end
   endgenerate

   // ------------------------------------------------------------ read ports
   function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
      logic [WIDTH-1:0] r;
      r = '0;
      if (addr_valid(a)) begin
         r = entries[a];
      end
      // wr_ok already implies IDLE, so forwarding is off while clearing.
      if ((BYPASS != 0) && wr_ok && (writeAddr == a)) begin
         r = writeData;
      end
      return r;
   endfunction

   always_comb begin
      rdDataA = read_port(rdAddrA);
   end

   always_comb begin
      rdDataB = read_port(rdAddrB);
   end

   // ------------------------------------------------------------ clear FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      case (state_reg)
         IDLE: begin
            if (clearReq) begin
               state_next = CLEAR;
               idx_next   = '0;
            end
         end
         CLEAR: begin
            if (idx_reg == LAST_IDX) begin
               state_next = DONE;
               idx_next   = '0;
            end else begin
               idx_next = idx_reg + 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   assign clearBusy = (state_reg != IDLE);
   assign clearDone = (state_reg == DONE);

endmodule

// File: tb/tb_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_reg_file_mp
//   Directed bench for reg_file_mp. Main instance uses the defaults
//   (DEPTH=32, ZERO_REG=1, BYPASS=1); a second instance with DEPTH=20,
//   ZERO_REG=0, BYPASS=0 shares the stimulus to cover out-of-range
//   addresses, a writable entry 0 and the non-forwarding read path.
// -----------------------------------------------------------------------------
module tb_reg_file_mp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  rdAddrA = '0;
   logic [4:0]  rdAddrB = '0;
   logic        writeEnable = 1'b0;
   logic [4:0]  writeAddr = '0;
   logic [31:0] writeData = '0;
   logic        clearReq = 1'b0;

   logic [31:0] rdDataA, rdDataB;
   logic        clearBusy, clearDone;
   logic [31:0] nb_rdDataA, nb_rdDataB;
   logic        nb_clearBusy, nb_clearDone;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   reg_file_mp #(
      .WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)
   ) dut (
      .clk(clk), .rst(rst),
      .rdAddrA(rdAddrA), .rdDataA(rdDataA),
      .rdAddrB(rdAddrB), .rdDataB(rdDataB),
      .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
      .clearReq(clearReq), .clearBusy(clearBusy), .clearDone(clearDone)
   );

   reg_file_mp #(
      .WIDTH(32), .DEPTH(20), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)
   ) dut_nb (
      .clk(clk), .rst(rst),
      .rdAddrA(rdAddrA), .rdDataA(nb_rdDataA),
      .rdAddrB(rdAddrB), .rdDataB(nb_rdDataB),
      .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
      .clearReq(clearReq), .clearBusy(nb_clearBusy), .clearDone(nb_clearDone)
   );

   function automatic logic [31:0] fillv(input int i);
      return 32'h1000_0000 + 32'(i) + 32'd1;
   endfunction

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) begin
         rdAddrA = 5'(i);
         rdAddrB = 5'(31 - i);
         #1;
         total_cnt++;
         if (rdDataA !== 32'h0) $display("FAIL reset_rdA addr %0d: got %h expected 0", i, rdDataA);
         else pass_cnt++;
         total_cnt++;
         if (rdDataB !== 32'h0) $display("FAIL reset_rdB addr %0d: got %h expected 0", 31 - i, rdDataB);
         else pass_cnt++;
         total_cnt++;
         if (nb_rdDataA !== 32'h0) $display("FAIL reset_nb_rdA addr %0d: got %h expected 0", i, nb_rdDataA);
         else pass_cnt++;
      end
      total_cnt++;
      if (clearBusy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", clearBusy);
      else pass_cnt++;
      total_cnt++;
      if (clearDone !== 1'b0) $display("FAIL reset_done: got %b expected 0", clearDone);
      else pass_cnt++;
      $display("reset: entries read zero, busy=%b done=%b", clearBusy, clearDone);
   endtask

   task automatic test_write_read();
      writeEnable = 1'b1; writeAddr = 5'd5; writeData = 32'hDEADBEEF;
      step();
      writeAddr = 5'd31; writeData = 32'h12345678;
      step();
      writeEnable = 1'b0;
      rdAddrA = 5'd5; rdAddrB = 5'd31;
      #1;
      total_cnt++;
      if (rdDataA !== 32'hDEADBEEF) $display("FAIL wr_rd_a5: got %h expected deadbeef", rdDataA);
      else pass_cnt++;
      total_cnt++;
      if (rdDataB !== 32'h12345678) $display("FAIL wr_rd_b31: got %h expected 12345678", rdDataB);
      else pass_cnt++;
      total_cnt++;
      if (nb_rdDataA !== 32'hDEADBEEF) $display("FAIL nb_wr_rd_a5: got %h expected deadbeef", nb_rdDataA);
      else pass_cnt++;
      total_cnt++;
      if (nb_rdDataB !== 32'h0) $display("FAIL nb_out_of_range_31: got %h expected 0", nb_rdDataB);
      else pass_cnt++;
      $display("write/read: a5=%h b31=%h nb_b31=%h", rdDataA, rdDataB, nb_rdDataB);
   endtask

   task automatic test_zero_bypass();
      writeEnable = 1'b1; writeAddr = 5'd0; writeData = 32'hFFFFFFFF;
      step();
      writeEnable = 1'b0;
      rdAddrA = 5'd0;
      #1;
      total_cnt++;
      if (rdDataA !== 32'h0) $display("FAIL zero_reg: got %h expected 0", rdDataA);
      else pass_cnt++;
      total_cnt++;
      if (nb_rdDataA !== 32'hFFFFFFFF) $display("FAIL nb_entry0_write: got %h expected ffffffff", nb_rdDataA);
      else pass_cnt++;

      // Same-cycle write to 7 seen on port A before the edge.
      writeEnable = 1'b1; writeAddr = 5'd7; writeData = 32'hA5A5A5A5;
      rdAddrA = 5'd7;
      #1;
      total_cnt++;
      if (rdDataA !== 32'hA5A5A5A5) $display("FAIL bypass_a7: got %h expected a5a5a5a5", rdDataA);
      else pass_cnt++;
      total_cnt++;
      if (nb_rdDataA !== 32'h0) $display("FAIL nb_no_bypass_a7: got %h expected 0", nb_rdDataA);
      else pass_cnt++;
      step();
      writeEnable = 1'b0;
      #1;
      total_cnt++;
      if (nb_rdDataA !== 32'hA5A5A5A5) $display("FAIL nb_after_edge_a7: got %h expected a5a5a5a5", nb_rdDataA);
      else pass_cnt++;

      // Forwarding must not expose a rejected write to the zero entry.
      writeEnable = 1'b1; writeAddr = 5'd0; writeData = 32'h00001234;
      rdAddrB = 5'd0;
      #1;
      total_cnt++;
      if (rdDataB !== 32'h0) $display("FAIL bypass_zero_reg: got %h expected 0", rdDataB);
      else pass_cnt++;
      total_cnt++;
      if (nb_rdDataB !== 32'hFFFFFFFF) $display("FAIL nb_no_bypass_b0: got %h expected ffffffff", nb_rdDataB);
      else pass_cnt++;
      step();
      writeEnable = 1'b0;
      $display("zero/bypass: a7 forwarded, zero entry held");
   endtask

   task automatic test_bulk_clear();
      for (int i = 0; i < 32; i++) begin
         writeEnable = 1'b1; writeAddr = 5'(i); writeData = fillv(i);
         step();
      end
      writeEnable = 1'b0;
      clearReq = 1'b1;
      step();
      clearReq = 1'b0;
      for (int c = 1; c <= 33; c++) begin
         rdAddrA = (c >= 2) ? 5'(c - 2) : 5'd0;
         rdAddrB = (c <= 32) ? 5'(c - 1) : 5'd0;
         #1;
         total_cnt++;
         if (clearBusy !== 1'b1) $display("FAIL clr_busy cycle %0d: got %b expected 1", c, clearBusy);
         else pass_cnt++;
         total_cnt++;
         if (clearDone !== (c == 33)) $display("FAIL clr_done cycle %0d: got %b expected %b", c, clearDone, (c == 33));
         else pass_cnt++;
         if (c >= 2) begin
            total_cnt++;
            if (rdDataA !== 32'h0) $display("FAIL clr_zeroed cycle %0d addr %0d: got %h expected 0", c, c - 2, rdDataA);
            else pass_cnt++;
         end
         if (c <= 32) begin
            total_cnt++;
            if (rdDataB !== ((c == 1) ? 32'h0 : fillv(c - 1)))
               $display("FAIL clr_pending cycle %0d addr %0d: got %h expected %h", c, c - 1, rdDataB, ((c == 1) ? 32'h0 : fillv(c - 1)));
            else pass_cnt++;
         end
         total_cnt++;
         if (nb_clearBusy !== (c <= 21)) $display("FAIL nb_clr_busy cycle %0d: got %b expected %b", c, nb_clearBusy, (c <= 21));
         else pass_cnt++;
         total_cnt++;
         if (nb_clearDone !== (c == 21)) $display("FAIL nb_clr_done cycle %0d: got %b expected %b", c, nb_clearDone, (c == 21));
         else pass_cnt++;
         step();
      end
      total_cnt++;
      if (clearBusy !== 1'b0 || clearDone !== 1'b0) $display("FAIL clr_end: got busy=%b done=%b expected 0/0", clearBusy, clearDone);
      else pass_cnt++;
      for (int i = 0; i < 32; i++) begin
         rdAddrA = 5'(i);
         #1;
         total_cnt++;
         if (rdDataA !== 32'h0) $display("FAIL clr_all addr %0d: got %h expected 0", i, rdDataA);
         else pass_cnt++;
      end
      $display("bulk clear: 33 busy cycles, done in cycle 33");
   endtask

   task automatic test_collisions();
      int c;
      int done_at;
      int n;
      c = 1;
      done_at = 0;
      clearReq = 1'b1;
      step();
      clearReq = 1'b0;
      while (clearBusy === 1'b1 && c < 80) begin
         if (c == 6) begin
            writeEnable = 1'b1; writeAddr = 5'd3; writeData = 32'h55;
            rdAddrA = 5'd3;
            #1;
            total_cnt++;
            if (rdDataA !== 32'h0) $display("FAIL busy_no_bypass: got %h expected 0", rdDataA);
            else pass_cnt++;
         end
         if (c == 10) clearReq = 1'b1;
         if (clearDone === 1'b1) done_at = c;
         step();
         writeEnable = 1'b0;
         clearReq = 1'b0;
         c++;
      end
      total_cnt++;
      if (done_at !== 33) $display("FAIL busy_done_cycle: got %0d expected 33", done_at);
      else pass_cnt++;
      total_cnt++;
      if (c !== 34) $display("FAIL busy_length: got %0d expected 34", c);
      else pass_cnt++;
      rdAddrA = 5'd3;
      #1;
      total_cnt++;
      if (rdDataA !== 32'h0) $display("FAIL dropped_write_a3: got %h expected 0", rdDataA);
      else pass_cnt++;

      // Write and clear request on the same edge: the write lands first.
      writeEnable = 1'b1; writeAddr = 5'd9; writeData = 32'h99;
      clearReq = 1'b1;
      step();
      writeEnable = 1'b0;
      clearReq = 1'b0;
      rdAddrA = 5'd9;
      #1;
      total_cnt++;
      if (rdDataA !== 32'h99) $display("FAIL wr_with_clr_lands: got %h expected 99", rdDataA);
      else pass_cnt++;
      repeat (9) step();
      total_cnt++;
      if (rdDataA !== 32'h99) $display("FAIL wr_with_clr_before_idx9: got %h expected 99", rdDataA);
      else pass_cnt++;
      step();
      total_cnt++;
      if (rdDataA !== 32'h0) $display("FAIL wr_with_clr_cleared: got %h expected 0", rdDataA);
      else pass_cnt++;

      n = 0;
      while (clearDone !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      total_cnt++;
      if (clearDone !== 1'b1) $display("FAIL wait_done: got %b expected 1", clearDone);
      else pass_cnt++;
      // Request during DONE is dropped; held into IDLE it starts a new clear.
      clearReq = 1'b1;
      step();
      total_cnt++;
      if (clearBusy !== 1'b0) $display("FAIL req_in_done_ignored: got %b expected 0", clearBusy);
      else pass_cnt++;
      step();
      clearReq = 1'b0;
      #1;
      total_cnt++;
      if (clearBusy !== 1'b1 || clearDone !== 1'b0) $display("FAIL req_in_idle_starts: got busy=%b done=%b expected 1/0", clearBusy, clearDone);
      else pass_cnt++;
      n = 0;
      while (clearBusy === 1'b1 && n < 60) begin
         step();
         n++;
      end
      total_cnt++;
      if (clearBusy !== 1'b0) $display("FAIL wait_idle: got %b expected 0", clearBusy);
      else pass_cnt++;
      $display("collisions: done at cycle %0d, loop count %0d", done_at, c);
   endtask

   task automatic test_async_reset();
      int done_seen;
      done_seen = 0;
      for (int i = 1; i < 32; i++) begin
         writeEnable = 1'b1; writeAddr = 5'(i); writeData = fillv(i);
         step();
      end
      writeEnable = 1'b0;
      clearReq = 1'b1;
      step();
      clearReq = 1'b0;
      repeat (10) step();
      #2;
      total_cnt++;
      if (clearBusy !== 1'b1) $display("FAIL pre_reset_busy: got %b expected 1", clearBusy);
      else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++;
      if (clearBusy !== 1'b0 || clearDone !== 1'b0) $display("FAIL async_reset_flags: got busy=%b done=%b expected 0/0", clearBusy, clearDone);
      else pass_cnt++;
      for (int i = 0; i < 32; i++) begin
         rdAddrA = 5'(i);
         #1;
         total_cnt++;
         if (rdDataA !== 32'h0) $display("FAIL async_reset_entry %0d: got %h expected 0", i, rdDataA);
         else pass_cnt++;
         if (clearDone === 1'b1) done_seen++;
      end
      step();
      rst = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         if (clearDone !== 1'b0 || clearBusy !== 1'b0) done_seen++;
      end
      total_cnt++;
      if (done_seen !== 0) $display("FAIL async_reset_no_done: got %0d stray busy/done cycles expected 0", done_seen);
      else pass_cnt++;
      $display("async reset: clear aborted, busy=%b done=%b", clearBusy, clearDone);
   endtask

   initial begin
      #1;
      test_reset();
      test_write_read();
      test_zero_bypass();
      test_bulk_clear();
      test_collisions();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule
